wb_write_queue: RTL and testbench
=================================

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DW, 16, data width of each architectural register.
REQ-002 SHALL have parameter NREGS, 8, number of architectural registers; the address width is clog2(NREGS).
REQ-003 SHALL have parameter DEPTH, 2, number of queue entries; legal values are powers of two, 2 to 8.
REQ-004 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port in_valid  in  1  write-back request present.
REQ-007 SHALL have port in_ready  out  1  queue can accept a request this cycle.
REQ-008 SHALL have port in_addr  in  clog2(NREGS)  destination register.
REQ-009 SHALL have port in_data  in  DW  write-back value.
REQ-010 SHALL have port wb_hold  in  1  register array not writable this cycle.
REQ-011 SHALL have port reg_we  out  NREGS  one-hot per-register write enable.
REQ-012 SHALL have port reg_din  out  DW  data broadcast to all registers.
REQ-013 SHALL have port occupancy  out  clog2(DEPTH)+1  number of valid entries.
REQ-014 SHALL have ports rd_addr_a/rd_addr_b  in  clog2(NREGS)  operand addresses for forwarding lookup.
REQ-015 SHALL have ports fwd_hit_a/fwd_hit_b  out  1  and fwd_data_a/fwd_data_b  out  DW  forwarding results.

Function
REQ-016 SHALL accept a request on a rising edge when in_valid and in_ready are both 1.
REQ-017 SHALL drive in_ready = 1 exactly when occupancy < DEPTH; a pop in the same cycle does not raise in_ready.
REQ-018 SHALL treat an accepted request with in_addr = 0 as complete: it is not enqueued, and register 0 is never written.
REQ-019 SHALL keep entries in FIFO order, using wrapping read and write pointers of clog2(DEPTH) bits.
REQ-020 SHALL drive the head entry combinationally when occupancy > 0 and wb_hold = 0: reg_we = one-hot(head address), reg_din = head data.
REQ-021 SHALL pop the head entry on the edge where REQ-020 holds.
REQ-022 SHALL drive reg_we = all zeros when the queue is empty or wb_hold = 1, with reg_din = head data, or 0 when the queue is empty.
REQ-023 SHALL push and pop on the same edge when both occur, leaving occupancy unchanged.
REQ-024 SHALL guarantee a minimum latency of one edge: a value accepted at edge N reaches the register at edge N+1 at the earliest.
REQ-025 SHALL never overflow: in_valid while in_ready = 0 has no effect, and the requester holds its data.

Reset
REQ-026 SHALL clear the pointers, occupancy and valid bits immediately on rst, asynchronously.
REQ-027 SHALL drive these values while in reset and until the first push: reg_we = 0, reg_din = 0, in_ready = 1, occupancy = 0, fwd_hit_* = 0, fwd_data_* = 0.
REQ-028 SHALL discard pending entries when reset is asserted mid-operation; they are never written.

Configuration
REQ-029 SHALL compile operand forwarding in when macro WB_QUEUE_FWD_EN is defined.
- fwd_hit_x = 1 when any valid entry's address equals rd_addr_x and rd_addr_x is not 0.
- fwd_data_x = data of the youngest matching entry.
- Forwarding is combinational and includes the head entry even while it is being popped.
REQ-030 SHALL tie fwd_hit_* and fwd_data_* to 0 when WB_QUEUE_FWD_EN is not defined, and add no comparator logic.

Structure
REQ-031 SHALL take DW, NREGS, the address width, and the packed entry type {addr, data} from shared package regfile_pkg.
REQ-032 SHALL place the storage and pointer logic in one sub-module, wbq_fifo; the top level contains the zero-address filter, one-hot decode and forwarding.

Verification
REQ-033 SHALL cover this scenario: after reset, push (addr 3, 0xA5A5) -> next cycle reg_we = 0x08, reg_din = 0xA5A5; one cycle later reg_we = 0 and occupancy = 0.
REQ-034 SHALL cover this scenario: hold wb_hold = 1 and push (1, 0x1111) then (2, 0x2222) -> occupancy = 2, in_ready = 0; a third in_valid is ignored; releasing the hold gives reg_we 0x02 then 0x04.
REQ-035 SHALL cover this scenario: push (0, 0xFFFF) -> accepted, occupancy stays 0, reg_we never 0x01.
REQ-036 SHALL cover this scenario: with WB_QUEUE_FWD_EN defined and wb_hold = 1, push (5, 0x0001) then (5, 0x0002), rd_addr_a = 5 -> fwd_hit_a = 1, fwd_data_a = 0x0002; rd_addr_b = 0 -> fwd_hit_b = 0.
REQ-037 SHALL cover this scenario: with occupancy = 1, push and pop on the same edge -> occupancy stays 1 and ordering is preserved; assert rst mid-stream -> reg_we = 0 immediately and occupancy = 0.
REQ-038 SHALL cover this scenario: with DEPTH = 4, 20 back-to-back pushes with wb_hold toggled randomly -> all writes reach reg_we in order, pointers wrap correctly, and nothing is lost.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the architectural register file and its write-back
// path: data width, register count, address width, the packed queue entry
// type {addr, data} and a one-hot address decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_DW    = 16;
    localparam int RF_NREGS = 8;
    localparam int RF_AW    = $clog2(RF_NREGS);

    typedef struct packed {
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } wb_entry_t;

    function automatic logic [RF_NREGS-1:0] onehot_dec(input logic [RF_AW-1:0] a);
        logic [RF_NREGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wbq_fifo.sv
// -----------------------------------------------------------------------------
// wbq_fifo
// Storage and pointer logic of the write-back queue. DEPTH entries of
// wb_entry_t kept in FIFO order with wrapping read/write pointers of
// clog2(DEPTH) bits, a per-entry valid bit and an occupancy counter.
// Pointers, occupancy and valid bits clear asynchronously on rst; the data
// array is not reset (valid bits qualify it).
//
// Ports
//   clk, rst       clock, async active-high reset
//   push_i         write push_entry_i at the tail (ignored when full)
//   pop_i          drop the head entry (ignored when empty)
//   push_entry_i   entry to enqueue
//   head_o         entry at the read pointer
//   occupancy_o    number of valid entries, 0..DEPTH
//   full_o         occupancy_o == DEPTH
//   entries_o      raw storage, for forwarding lookup
//   valid_o        per-slot valid bits
//   rd_ptr_o       read pointer (oldest slot), for age ordering
// -----------------------------------------------------------------------------
module wbq_fifo
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int OW    = PW + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  wb_entry_t               push_entry_i,
    output wb_entry_t               head_o,
    output logic [OW-1:0]           occupancy_o,
    output logic                    full_o,
    output wb_entry_t [DEPTH-1:0]   entries_o,
    output logic [DEPTH-1:0]        valid_o,
    output logic [PW-1:0]           rd_ptr_o
);

    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]          occ_q, occ_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    wb_entry_t [DEPTH-1:0]  mem_q;

    logic                   push_ok;
    logic                   pop_ok;

    assign full_o  = (occ_q == OW'(DEPTH));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && (occ_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        valid_d  = valid_q;
        if (push_ok) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        // A push never targets the head slot while the queue is non-empty,
        // so clearing the head valid bit cannot undo a same-edge push.
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign occupancy_o = occ_q;
    assign entries_o   = mem_q;
    assign valid_o     = valid_q;
    assign rd_ptr_o    = rd_ptr_q;

endmodule

// File: rtl/wb_write_queue.sv
// -----------------------------------------------------------------------------
// wb_write_queue
// Write-back queue in front of the architectural register array. Accepted
// requests are buffered in a small FIFO (wbq_fifo) and drained one per cycle
// whenever the register array is writable (wb_hold = 0). Writes to register 0
// are accepted and dropped. Optional operand forwarding looks up pending
// entries for two read addresses.
//
// Build option: define WB_QUEUE_FWD_EN to include the forwarding comparators;
// otherwise fwd_hit_* / fwd_data_* are tied to 0.
//
// DW and NREGS must stay equal to the regfile_pkg values, since the queue
// entry type comes from that package.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   in_valid / in_ready      request handshake (accepted when both are 1)
//   in_addr, in_data         destination register and value
//   wb_hold                  register array not writable this cycle
//   reg_we                   one-hot register write enable
//   reg_din                  write data broadcast to all registers
//   occupancy                number of pending entries
//   rd_addr_a / rd_addr_b    operand addresses for forwarding
//   fwd_hit_a / fwd_hit_b    a pending entry targets that address
//   fwd_data_a / fwd_data_b  value of the youngest such entry
// -----------------------------------------------------------------------------
module wb_write_queue
    import regfile_pkg::*;
#(
    parameter  int DW    = RF_DW,
    parameter  int NREGS = RF_NREGS,
    parameter  int DEPTH = 2,
    localparam int AW    = RF_AW,
    localparam int PW    = $clog2(DEPTH),
    localparam int OW    = PW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AW-1:0]       in_addr,
    input  logic [DW-1:0]       in_data,
    input  logic                wb_hold,
    output logic [NREGS-1:0]    reg_we,
    output logic [DW-1:0]       reg_din,
    output logic [OW-1:0]       occupancy,
    input  logic [AW-1:0]       rd_addr_a,
    input  logic [AW-1:0]       rd_addr_b,
    output logic                fwd_hit_a,
    output logic                fwd_hit_b,
    output logic [DW-1:0]       fwd_data_a,
    output logic [DW-1:0]       fwd_data_b
);

    wb_entry_t              entry_in;
    wb_entry_t              head;
    wb_entry_t [DEPTH-1:0]  fifo_entries;
    logic [DEPTH-1:0]       fifo_valid;
    logic [PW-1:0]          fifo_rd_ptr;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;
    logic                   not_empty;

    assign in_ready  = !fifo_full;
    assign not_empty = (occupancy != '0);

    // Register 0 is hard-wired: the request completes at acceptance.
    assign push     = in_valid && in_ready && (in_addr != '0);
    assign pop      = not_empty && !wb_hold;
    assign entry_in = '{addr: in_addr, data: in_data};

    wbq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (pop),
        .push_entry_i (entry_in),
        .head_o       (head),
        .occupancy_o  (occupancy),
        .full_o       (fifo_full),
        .entries_o    (fifo_entries),
        .valid_o      (fifo_valid),
        .rd_ptr_o     (fifo_rd_ptr)
    );

    assign reg_we  = pop ? onehot_dec(head.addr) : '0;
    assign reg_din = not_empty ? head.data : '0;

`ifdef WB_QUEUE_FWD_EN
    logic [PW-1:0] slot;

    // Walk slots oldest to youngest starting at the read pointer; the last
    // match wins, giving the youngest entry. The head is included even on
    // the cycle it drains.
    always_comb begin
        fwd_hit_a  = 1'b0;
        fwd_hit_b  = 1'b0;
        fwd_data_a = '0;
        fwd_data_b = '0;
        slot       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = fifo_rd_ptr + PW'(k);
            if (fifo_valid[slot] && (rd_addr_a != '0) &&
                (fifo_entries[slot].addr == rd_addr_a)) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = fifo_entries[slot].data;
            end
            if (fifo_valid[slot] && (rd_addr_b != '0) &&
                (fifo_entries[slot].addr == rd_addr_b)) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = fifo_entries[slot].data;
            end
        end
    end
`else
    logic unused_fwd;

    assign fwd_hit_a  = 1'b0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_data_a = '0;
    assign fwd_data_b = '0;
    assign unused_fwd = ^{rd_addr_a, rd_addr_b, fifo_entries, fifo_valid, fifo_rd_ptr};
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;
    import regfile_pkg::*;

    localparam int DW    = RF_DW;
    localparam int NREGS = RF_NREGS;
    localparam int AW    = RF_AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           in_valid;
    logic           wb_hold;
    logic [AW-1:0]  in_addr;
    logic [DW-1:0]  in_data;
    logic [AW-1:0]  rd_addr_a;
    logic [AW-1:0]  rd_addr_b;

    // index 0: DEPTH=2 instance, index 1: DEPTH=4 instance (same stimulus)
    logic              rdy [2];
    logic [NREGS-1:0]  we  [2];
    logic [DW-1:0]     din [2];
    logic              ha  [2];
    logic              hb  [2];
    logic [DW-1:0]     fda [2];
    logic [DW-1:0]     fdb [2];
    logic [3:0]        occ [2];
    logic [1:0]        occ2;
    logic [2:0]        occ4;

    assign occ[0] = {2'b00, occ2};
    assign occ[1] = {1'b0, occ4};

    wb_write_queue #(.DW(DW), .NREGS(NREGS), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_addr(in_addr), .in_data(in_data), .wb_hold(wb_hold),
        .reg_we(we[0]), .reg_din(din[0]), .occupancy(occ2),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .fwd_hit_a(ha[0]), .fwd_hit_b(hb[0]), .fwd_data_a(fda[0]), .fwd_data_b(fdb[0])
    );

    wb_write_queue #(.DW(DW), .NREGS(NREGS), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_addr(in_addr), .in_data(in_data), .wb_hold(wb_hold),
        .reg_we(we[1]), .reg_din(din[1]), .occupancy(occ4),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .fwd_hit_a(ha[1]), .fwd_hit_b(hb[1]), .fwd_data_a(fda[1]), .fwd_data_b(fdb[1])
    );

    // Reference model: one queue of pending writes per instance.
    wb_entry_t q [2][$];
    int        depth [2] = '{2, 4};
    int        pops  [2] = '{0, 0};
    int        seen  [2] = '{0, 0};
    int        total = 0;
    int        bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void fwd_model(input int d, input logic [AW-1:0] ra,
                                      output logic hit, output logic [DW-1:0] dat);
        hit = 1'b0;
        dat = '0;
        if (ra != '0) begin
            for (int i = 0; i < q[d].size(); i++) begin
                if (q[d][i].addr == ra) begin
                    hit = 1'b1;
                    dat = q[d][i].data;
                end
            end
        end
`ifndef WB_QUEUE_FWD_EN
        hit = 1'b0;
        dat = '0;
`endif
    endfunction

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int               n;
            logic [NREGS-1:0] exp_we;
            logic [DW-1:0]    exp_din;
            logic             eh;
            logic [DW-1:0]    ed;
            n       = q[d].size();
            exp_we  = '0;
            exp_din = '0;
            if (n > 0) begin
                exp_din = q[d][0].data;
                if (!wb_hold) exp_we[q[d][0].addr] = 1'b1;
            end
            chk($sformatf("d%0d.in_ready", d), 32'(rdy[d]), 32'(n < depth[d]));
            chk($sformatf("d%0d.occupancy", d), 32'(occ[d]), 32'(n));
            chk($sformatf("d%0d.reg_we", d), 32'(we[d]), 32'(exp_we));
            chk($sformatf("d%0d.reg_din", d), 32'(din[d]), 32'(exp_din));
            fwd_model(d, rd_addr_a, eh, ed);
            chk($sformatf("d%0d.fwd_hit_a", d), 32'(ha[d]), 32'(eh));
            chk($sformatf("d%0d.fwd_data_a", d), 32'(fda[d]), 32'(ed));
            fwd_model(d, rd_addr_b, eh, ed);
            chk($sformatf("d%0d.fwd_hit_b", d), 32'(hb[d]), 32'(eh));
            chk($sformatf("d%0d.fwd_data_b", d), 32'(fdb[d]), 32'(ed));
            if (we[d] !== '0) seen[d]++;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int n;
            n = q[d].size();
            if (n > 0 && !wb_hold) begin
                void'(q[d].pop_front());
                pops[d]++;
            end
            if (in_valid && n < depth[d] && in_addr != '0)
                q[d].push_back(wb_entry_t'{addr: in_addr, data: in_data});
        end
    endtask

    // Check outputs just after the falling edge, then advance one rising edge.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] dat, input logic h);
        in_valid = v;
        in_addr  = a;
        in_data  = dat;
        wb_hold  = h;
    endtask

    initial begin
        logic exp_hit;
        logic [DW-1:0] exp_fd;

        rst = 1'b1;
        rd_addr_a = '0;
        rd_addr_b = '0;
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        #1;
        check_all();
        chk("reset.occ2", 32'(occ2), 32'd0);
        chk("reset.ready2", 32'(rdy[0]), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single write reaches the register one edge after acceptance.
        drive(1'b1, 3'd3, 16'hA5A5, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        #1;
        chk("s1.we", 32'(we[0]), 32'h08);
        chk("s1.din", 32'(din[0]), 32'hA5A5);
        step();
        #1;
        chk("s1.we_after", 32'(we[0]), 32'h00);
        chk("s1.occ_after", 32'(occ2), 32'd0);
        step();

        // Fill under hold, overflow attempt ignored, drain in order.
        drive(1'b1, 3'd1, 16'h1111, 1'b1);
        step();
        drive(1'b1, 3'd2, 16'h2222, 1'b1);
        step();
        drive(1'b1, 3'd3, 16'h3333, 1'b1);
        #1;
        chk("s2.occ_full", 32'(occ2), 32'd2);
        chk("s2.ready_full", 32'(rdy[0]), 32'd0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        #1;
        chk("s2.we_first", 32'(we[0]), 32'h02);
        step();
        #1;
        chk("s2.we_second", 32'(we[0]), 32'h04);
        for (int i = 0; i < 4; i++) step();

        // Address 0 accepted but never queued or written.
        drive(1'b1, 3'd0, 16'hFFFF, 1'b0);
        #1;
        chk("s3.ready", 32'(rdy[0]), 32'd1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        #1;
        chk("s3.occ", 32'(occ2), 32'd0);
        chk("s3.we", 32'(we[0]), 32'h00);
        step();

        // Forwarding picks the youngest of two entries to the same register.
        drive(1'b1, 3'd5, 16'h0001, 1'b1);
        step();
        drive(1'b1, 3'd5, 16'h0002, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b1);
        rd_addr_a = 3'd5;
        rd_addr_b = 3'd0;
`ifdef WB_QUEUE_FWD_EN
        exp_hit = 1'b1;
        exp_fd  = 16'h0002;
`else
        exp_hit = 1'b0;
        exp_fd  = 16'h0000;
`endif
        #1;
        chk("s4.hit_a", 32'(ha[0]), 32'(exp_hit));
        chk("s4.data_a", 32'(fda[0]), 32'(exp_fd));
        chk("s4.hit_b", 32'(hb[0]), 32'd0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        rd_addr_a = '0;

        // Simultaneous push and pop at occupancy 1, then reset mid-stream.
        drive(1'b1, 3'd4, 16'h4444, 1'b0);
        step();
        drive(1'b1, 3'd6, 16'h6666, 1'b0);
        #1;
        chk("s5.we_head", 32'(we[0]), 32'h10);
        step();
        drive(1'b1, 3'd7, 16'h7777, 1'b1);
        #1;
        chk("s5.occ_kept", 32'(occ2), 32'd1);
        chk("s5.din_order", 32'(din[0]), 32'h6666);
        step();
        drive(1'b0, '0, '0, 1'b0);
        #1;
        chk("s5.we_before_rst", 32'(we[0]), 32'h40);
        rst = 1'b1;
        #1;
        chk("s5.we_rst2", 32'(we[0]), 32'h00);
        chk("s5.occ_rst2", 32'(occ2), 32'd0);
        chk("s5.we_rst4", 32'(we[1]), 32'h00);
        chk("s5.occ_rst4", 32'(occ4), 32'd0);
        q[0].delete();
        q[1].delete();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Random traffic with random hold; wraps both pointer sets many times.
        for (int i = 0; i < 150; i++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            in_addr   = ($urandom_range(0, 9) == 0) ? 3'd0 : AW'($urandom_range(1, NREGS - 1));
            in_data   = DW'($urandom);
            wb_hold   = $urandom_range(0, 1) == 1;
            rd_addr_a = AW'($urandom_range(0, NREGS - 1));
            rd_addr_b = AW'($urandom_range(0, NREGS - 1));
            step();
        end
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step();
        #1;
        chk("drain.occ4", 32'(occ4), 32'd0);
        chk("drain.writes2", 32'(seen[0]), 32'(pops[0]));
        chk("drain.writes4", 32'(seen[1]), 32'(pops[1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
